code_loader: RTL
================

Name: code_loader

Overview:
- Host-side writer for the instruction store; the other end of its write and loop-control interface.
- Accepts a byte stream over a valid/ready handshake and decodes framed commands.
- Drives the store's single-line write port (is_write / write_line / write_data) and the loop-register update strobes (code_reset_address / code_reset_count).
- Sits between the host link (UART/SPI byte front-end) and the code store, so programs and loop settings can be loaded at runtime.

Parameters:
- code_size, 12, width of one code word; must match the code store.
- max_code_line, 100, highest legal line index; writes above it are suppressed.
- BPW (localparam), (code_size+7)/8, bytes per code word; 2 at the default.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high; returns the block to IDLE and clears all outputs.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts the byte this cycle; a byte transfers when in_valid && in_ready.
- is_write  output  1  one-cycle write strobe to the code store.
- write_line  output  32  target line for is_write.
- write_data  output  code_size  word for is_write.
- code_reset_address  output  32  loop address value.
- update_code_reset_address  output  1  one-cycle strobe qualifying code_reset_address.
- code_reset_count  output  32  loop count value.
- update_code_reset_count  output  1  one-cycle strobe qualifying code_reset_count.
- busy  output  1  a command is in progress (state != IDLE).
- done  output  1  one-cycle pulse when a command completes.
- error  output  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0 except in_ready, which is 1. State is IDLE; internal counters are 0.
- All outputs are registered. Every strobe is high for exactly one cycle.
- Frame format: one command byte, then payload. Multi-byte fields are little-endian.
  - 0x01 WRITE_BLOCK: addr (4 bytes), len (4 bytes, word count), then len words of BPW bytes each.
  - 0x02 SET_ADDR: value (4 bytes).
  - 0x03 SET_COUNT: value (4 bytes).
- Word assembly: BPW bytes form one word, LSB byte first. Bits above code_size in the last byte are ignored.
- States: IDLE, ADDR, LEN, DATA, VAL, DONE.
  - IDLE: on an accepted byte, 0x01 -> ADDR; 0x02 or 0x03 -> VAL, with the kind latched.
  - IDLE, any other command byte: the byte is consumed, error is set, state stays IDLE.
  - ADDR -> LEN after 4 bytes.
  - LEN -> DATA after 4 bytes. If len == 0, LEN goes to DONE instead.
  - DATA: after each BPW-th byte, is_write pulses the next cycle with write_line = addr + word_idx and write_data = the assembled word.
  - DATA -> DONE when the byte completing word len-1 is accepted.
  - VAL -> DONE after 4 bytes. The matching update strobe pulses in the DONE cycle with the 32-bit value.
  - DONE: lasts one cycle; done = 1, in_ready = 0, then -> IDLE.
- Timing: if the final byte is accepted in cycle N, the last is_write (or update strobe) and done are both high in N+1. in_ready is 1 again in N+2.
- Accepting a new command byte in IDLE clears error.
- Range check: if addr + word_idx > max_code_line, is_write is suppressed for that word, error is set, and the rest of the payload is still consumed.
- Address arithmetic is 32-bit with wrap; a wrapped address counts as out of range.
- word_idx and the byte counter are 32-bit. len up to 2^32-1 is legal.
- in_valid may drop mid-frame: the FSM holds state indefinitely with no timeout.
- Synchronous reset mid-frame: the partial frame is discarded, no strobe is issued, outputs return to reset values the next cycle.
- Bytes are never dropped while in_ready = 1. in_ready depends only on state.

Decomposition:
- Package code_loader_pkg holds:
  - typedef enum state_t {IDLE, ADDR, LEN, DATA, VAL, DONE};
  - command constants CMD_WRITE_BLOCK = 8'h01, CMD_SET_ADDR = 8'h02, CMD_SET_COUNT = 8'h03.
- One sub-module, le_shift_assembler: a byte-to-N-bit little-endian accumulator with a byte counter and a full flag. It is reused for the 32-bit fields and for code words.

Test Plan:
- Block write: stream 01, addr 05 00 00 00, len 02 00 00 00, words 34 0A, CD 0F -> is_write at line 5 = 0xA34, then line 6 = 0xFCD; done coincides with the second write; error = 0.
- Loop programming: stream 02 10 00 00 00, then 03 03 00 00 00 -> update_code_reset_address pulses with 0x10, then update_code_reset_count pulses with 3; two done pulses; no is_write.
- Range: WRITE_BLOCK with addr 99 (0x63) and len 3 -> writes at lines 99 and 100, line 101 suppressed, error = 1; the next command byte clears error.
- Bad command 0x7F, then a valid SET_ADDR -> error = 1 until the 0x02 byte is accepted; the strobe is issued normally.
- Backpressure/gaps: random in_valid gaps during a 4-word block -> writes are identical to the gap-free run, and every in_ready = 0 cycle occurs only in DONE.
- Reset mid-DATA, after 1 of 2 bytes of word 0 -> no is_write, busy = 0 next cycle; a following full frame writes correctly.

Source files
------------

// File: rtl/code_loader_pkg.sv
// Shared types and constants for the code store loader.
// Command encodings, FSM states and the write-line range check.
package code_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    VAL  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [7:0] CMD_WRITE_BLOCK = 8'h01;
  localparam logic [7:0] CMD_SET_ADDR    = 8'h02;
  localparam logic [7:0] CMD_SET_COUNT   = 8'h03;

  // A line is legal only if addr + idx neither wraps past 32 bits nor exceeds max_line.
  function automatic logic line_in_range(input logic [31:0] addr,
                                         input logic [31:0] idx,
                                         input logic [31:0] max_line);
    logic [32:0] sum;
    sum = {1'b0, addr} + {1'b0, idx};
    return (sum <= {1'b0, max_line});
  endfunction

endpackage

// File: rtl/code_loader_le_shift_assembler.sv
// Little-endian byte accumulator: each shifted byte lands above the previous ones,
// so after NBYTES shifts the first byte sits in the least significant position.
module le_shift_assembler #(
  parameter int NBYTES = 4,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic [7:0]       data,
  output logic [WIDTH-1:0] value,
  output logic             full
);

  localparam int W = 8 * NBYTES;

  logic [W-1:0] acc_r;
  logic [W-1:0] acc_s;
  logic [W-1:0] byte_s;
  logic [31:0]  cnt_r;

  // Next accumulator image including the byte presented this cycle.
  always_comb begin
    byte_s = W'(data);
    acc_s  = (acc_r >> 8) | (byte_s << (W - 8));
  end

  assign value = acc_s[WIDTH-1:0];
  assign full  = shift && (cnt_r == 32'(NBYTES - 1));

  // Accumulator and byte counter; the counter restarts once a field completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= '0;
      cnt_r <= 32'd0;
    end else if (shift) begin
      acc_r <= acc_s;
      cnt_r <= full ? 32'd0 : (cnt_r + 32'd1);
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/code_loader.sv
// Byte-stream command decoder that writes the code store and programs the loop registers.
// All outputs are registered; strobes are single-cycle and land together with done.
module code_loader
  import code_loader_pkg::*;
#(
  parameter int code_size     = 12,
  parameter int max_code_line = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 is_write,
  output logic [31:0]          write_line,
  output logic [code_size-1:0] write_data,
  output logic [31:0]          code_reset_address,
  output logic                 update_code_reset_address,
  output logic [31:0]          code_reset_count,
  output logic                 update_code_reset_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int BPW = (code_size + 7) / 8;

  state_t state_r, state_s;
  logic   kind_r, kind_s;  // 0: loop address, 1: loop count
  logic [31:0] addr_r, addr_s;
  logic [31:0] len_r, len_s;
  logic [31:0] word_idx_r, word_idx_s;

  logic                 in_ready_r, busy_r, done_r, done_s, error_r, error_s;
  logic                 is_write_r, is_write_s;
  logic [31:0]          write_line_r, write_line_s;
  logic [code_size-1:0] write_data_r, write_data_s;
  logic [31:0]          cra_r, cra_s, crc_r, crc_s;
  logic                 upd_a_r, upd_a_s, upd_c_r, upd_c_s;

  logic                 accept_s, field_shift_s, word_shift_s;
  logic [31:0]          field_value_s;
  logic                 field_full_s;
  logic [code_size-1:0] word_value_s;
  logic                 word_full_s;

  assign accept_s      = in_valid && in_ready_r;
  assign field_shift_s = accept_s && ((state_r == ADDR) || (state_r == LEN) || (state_r == VAL));
  assign word_shift_s  = accept_s && (state_r == DATA);

  le_shift_assembler #(.NBYTES(4), .WIDTH(32)) u_field (
    .clk   (clk),
    .reset (reset),
    .shift (field_shift_s),
    .data  (in_data),
    .value (field_value_s),
    .full  (field_full_s)
  );

  le_shift_assembler #(.NBYTES(BPW), .WIDTH(code_size)) u_word (
    .clk   (clk),
    .reset (reset),
    .shift (word_shift_s),
    .data  (in_data),
    .value (word_value_s),
    .full  (word_full_s)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_s      = state_r;
    kind_s       = kind_r;
    addr_s       = addr_r;
    len_s        = len_r;
    word_idx_s   = word_idx_r;
    is_write_s   = 1'b0;
    write_line_s = write_line_r;
    write_data_s = write_data_r;
    cra_s        = cra_r;
    crc_s        = crc_r;
    upd_a_s      = 1'b0;
    upd_c_s      = 1'b0;
    error_s      = error_r;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (in_data)
            CMD_WRITE_BLOCK: begin
              state_s = ADDR;
              error_s = 1'b0;
            end
            CMD_SET_ADDR: begin
              state_s = VAL;
              kind_s  = 1'b0;
              error_s = 1'b0;
            end
            CMD_SET_COUNT: begin
              state_s = VAL;
              kind_s  = 1'b1;
              error_s = 1'b0;
            end
            default: error_s = 1'b1;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (field_full_s) begin
          addr_s  = field_value_s;
          state_s = LEN;
        end else begin
          state_s = ADDR;
        end
      end
      LEN: begin
        if (field_full_s) begin
          len_s      = field_value_s;
          word_idx_s = 32'd0;
          state_s    = (field_value_s == 32'd0) ? DONE : DATA;
        end else begin
          state_s = LEN;
        end
      end
      DATA: begin
        if (word_full_s) begin
          // Out-of-range words are consumed but never reach the store.
          if (line_in_range(addr_r, word_idx_r, 32'(max_code_line))) begin
            is_write_s   = 1'b1;
            write_line_s = addr_r + word_idx_r;
            write_data_s = word_value_s;
          end else begin
            error_s = 1'b1;
          end
          word_idx_s = word_idx_r + 32'd1;
          state_s    = (word_idx_r == (len_r - 32'd1)) ? DONE : DATA;
        end else begin
          state_s = DATA;
        end
      end
      VAL: begin
        if (field_full_s) begin
          if (kind_r) begin
            crc_s   = field_value_s;
            upd_c_s = 1'b1;
          end else begin
            cra_s   = field_value_s;
            upd_a_s = 1'b1;
          end
          state_s = DONE;
        end else begin
          state_s = VAL;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase

    done_s = (state_s == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      kind_r       <= 1'b0;
      addr_r       <= 32'd0;
      len_r        <= 32'd0;
      word_idx_r   <= 32'd0;
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      is_write_r   <= 1'b0;
      write_line_r <= 32'd0;
      write_data_r <= '0;
      cra_r        <= 32'd0;
      crc_r        <= 32'd0;
      upd_a_r      <= 1'b0;
      upd_c_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      kind_r       <= kind_s;
      addr_r       <= addr_s;
      len_r        <= len_s;
      word_idx_r   <= word_idx_s;
      in_ready_r   <= (state_s != DONE);
      busy_r       <= (state_s != IDLE);
      done_r       <= done_s;
      error_r      <= error_s;
      is_write_r   <= is_write_s;
      write_line_r <= write_line_s;
      write_data_r <= write_data_s;
      cra_r        <= cra_s;
      crc_r        <= crc_s;
      upd_a_r      <= upd_a_s;
      upd_c_r      <= upd_c_s;
    end
  end

  assign in_ready                  = in_ready_r;
  assign busy                      = busy_r;
  assign done                      = done_r;
  assign error                     = error_r;
  assign is_write                  = is_write_r;
  assign write_line                = write_line_r;
  assign write_data                = write_data_r;
  assign code_reset_address        = cra_r;
  assign update_code_reset_address = upd_a_r;
  assign code_reset_count          = crc_r;
  assign update_code_reset_count   = upd_c_r;

endmodule
